// File: rtl/corr_disp_array_pkg.sv
// corr_disp_array_pkg
//   Shared definitions for the stereo correlation array: argmax FSM states,
//   a constant-evaluable ceil(log2) and the derived-width helpers used by
//   the interface, the top and the testbench so that every width agrees.
package corr_disp_array_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    // Smallest r with 2**r >= value; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Lane total width: two DW x DW products summed, then WIN of those summed.
    function automatic int acc_width(input int dw, input int win);
        return 2 * dw + 1 + clog2(win);
    endfunction

    // Disparity index width, at least one bit even for a single lane.
    function automatic int idx_width(input int num_disp);
        return (clog2(num_disp) < 1) ? 1 : clog2(num_disp);
    endfunction

    // Window counter width, at least one bit even for WIN == 1.
    function automatic int cnt_width(input int win);
        return (clog2(win) < 1) ? 1 : clog2(win);
    endfunction

endpackage

// File: rtl/corr_disp_array_if.sv
// corr_disp_array_if
//   Sample-in / result-out bundle of the correlation array.
//   master: drives wen, d_l_1/d_l_2 (left re/im), d_r_1/d_r_2 (right re/im);
//           observes corr_out, best_disp, best_val, out_valid, overrun.
//   slave : the array itself (opposite directions).
interface corr_disp_array_if #(
    parameter int DW       = 8,
    parameter int NUM_DISP = 11,
    parameter int WIN      = 4
);
    import corr_disp_array_pkg::*;

    localparam int ACC_W = acc_width(DW, WIN);
    localparam int IDX_W = idx_width(NUM_DISP);

    logic                      wen;
    logic [DW-1:0]             d_l_1;
    logic [DW-1:0]             d_l_2;
    logic [DW-1:0]             d_r_1;
    logic [DW-1:0]             d_r_2;
    logic [NUM_DISP*ACC_W-1:0] corr_out;
    logic [IDX_W-1:0]          best_disp;
    logic [ACC_W-1:0]          best_val;
    logic                      out_valid;
    logic                      overrun;

    modport master (
        output wen, d_l_1, d_l_2, d_r_1, d_r_2,
        input  corr_out, best_disp, best_val, out_valid, overrun
    );

    modport slave (
        input  wen, d_l_1, d_l_2, d_r_1, d_r_2,
        output corr_out, best_disp, best_val, out_valid, overrun
    );

endinterface

// File: rtl/corr_disp_array_lane.sv
// corr_lane
//   One disparity lane: registered products (P1), registered sum (P2) and a
//   window accumulator. Window position and accumulate strobe come from the
//   top so that all lanes stay in lock-step.
//   Ports: clk, rst; l_re/l_im lane sample; r_re/r_im right reference;
//          acc_en accumulate strobe; acc_first first sample of a window;
//          total value the accumulator takes on this edge (acc+sum or sum).
module corr_lane #(
    parameter int DW    = 8,
    parameter int ACC_W = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    l_re,
    input  logic [DW-1:0]    l_im,
    input  logic [DW-1:0]    r_re,
    input  logic [DW-1:0]    r_im,
    input  logic             acc_en,
    input  logic             acc_first,
    output logic [ACC_W-1:0] total
);
    localparam int PROD_W = 2 * DW;
    localparam int SUM_W  = 2 * DW + 1;

    logic [PROD_W-1:0] prod_re;
    logic [PROD_W-1:0] prod_im;
    logic [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]  acc;

    // First window sample restarts the total; the top snapshots this value
    // on the last sample so the snapshot needs no extra cycle.
    assign total = acc_first ? ACC_W'(sum) : acc + ACC_W'(sum);

    // NOTE: state updates use <= so every register samples pre-edge values;
    // with = the sum would see this edge's new products and skip a stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_re <= '0;
            prod_im <= '0;
            sum     <= '0;
            acc     <= '0;
        end else begin
            prod_re <= PROD_W'(l_re) * PROD_W'(r_re);
            prod_im <= PROD_W'(l_im) * PROD_W'(r_im);
            sum     <= SUM_W'(prod_re) + SUM_W'(prod_im);
            if (acc_en) acc <= total;
        end
    end

endmodule

// File: rtl/corr_disp_array.sv
// corr_disp_array
//   Parametrised stereo correlation array. Left samples shift through a
//   NUM_DISP-deep chain, every stage is correlated against the current right
//   sample, lanes accumulate over WIN accepted samples, lane totals are
//   snapshotted to corr_out and a serial argmax reports the best lane.
//   Ports: clk, rst (async, active-high); bus (slave side of
//          corr_disp_array_if: wen, d_l_*, d_r_* in; corr_out, best_disp,
//          best_val, out_valid, overrun out).
module corr_disp_array
    import corr_disp_array_pkg::*;
#(
    parameter int DW       = 8,
    parameter int NUM_DISP = 11,
    parameter int WIN      = 4
) (
    input  logic             clk,
    input  logic             rst,
    corr_disp_array_if.slave bus
);
    localparam int ACC_W = acc_width(DW, WIN);
    localparam int IDX_W = idx_width(NUM_DISP);
    localparam int CNT_W = cnt_width(WIN);

    logic [DW-1:0]    lane_re [NUM_DISP];
    logic [DW-1:0]    lane_im [NUM_DISP];
    logic [DW-1:0]    ref_re;
    logic [DW-1:0]    ref_im;
    logic             v0, v1, v2;
    logic [CNT_W-1:0] cnt;
    logic             win_last;
    logic             win_done;
    logic [ACC_W-1:0] total [NUM_DISP];
    logic [ACC_W-1:0] snap  [NUM_DISP];

    scan_state_e      state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [IDX_W-1:0] best_idx, best_idx_n;
    logic [ACC_W-1:0] best, best_n;
    logic [IDX_W-1:0] best_disp_q, best_disp_n;
    logic [ACC_W-1:0] best_val_q, best_val_n;
    logic             valid_q, valid_n;
    logic             overrun_q, overrun_n;
    logic             snap_en;
    logic [IDX_W-1:0] cand_idx;
    logic [ACC_W-1:0] cand_val;
    logic [NUM_DISP*ACC_W-1:0] corr_flat;

    // NOTE: the chain is a plain register array, so it is reset like any
    // other state; deeper lanes then correlate as zero until primed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_DISP; k++) begin
                lane_re[k] <= '0;
                lane_im[k] <= '0;
            end
            ref_re <= '0;
            ref_im <= '0;
        end else if (bus.wen) begin
            lane_re[0] <= bus.d_l_1;
            lane_im[0] <= bus.d_l_2;
            for (int k = 1; k < NUM_DISP; k++) begin
                lane_re[k] <= lane_re[k-1];
                lane_im[k] <= lane_im[k-1];
            end
            ref_re <= bus.d_r_1;
            ref_im <= bus.d_r_2;
        end
    end

    // v0 marks the cycle the shifted chain is presented to the multipliers,
    // v1 tags the products, v2 tags the sums entering the accumulators.
    assign win_last = (cnt == CNT_W'(WIN - 1));
    assign win_done = v2 && win_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0  <= 1'b0;
            v1  <= 1'b0;
            v2  <= 1'b0;
            cnt <= '0;
        end else begin
            v0 <= bus.wen;
            v1 <= v0;
            v2 <= v1;
            if (v2) cnt <= win_last ? '0 : cnt + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < NUM_DISP; k++) begin : g_lane
        corr_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .l_re      (lane_re[k]),
            .l_im      (lane_im[k]),
            .r_re      (ref_re),
            .r_im      (ref_im),
            .acc_en    (v2),
            .acc_first (cnt == '0),
            .total     (total[k])
        );
    end

    // Argmax: strict '>' so ties keep the lower index.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        best_idx_n  = best_idx;
        best_n      = best;
        best_disp_n = best_disp_q;
        best_val_n  = best_val_q;
        valid_n     = 1'b0;
        overrun_n   = overrun_q;
        snap_en     = 1'b0;
        cand_idx    = best_idx;
        cand_val    = best;
        case (state)
            IDLE: begin
                if (win_done) begin
                    snap_en = 1'b1;
                    if (NUM_DISP == 1) begin
                        best_disp_n = '0;
                        best_val_n  = total[0];
                        valid_n     = 1'b1;
                    end else begin
                        state_n    = SCAN;
                        best_idx_n = '0;
                        best_n     = total[0];
                        idx_n      = IDX_W'(1);
                    end
                end
            end
            SCAN: begin
                // A window finishing mid-scan would overwrite the snapshot
                // being scanned, so it is dropped and flagged instead.
                if (win_done) overrun_n = 1'b1;
                if (snap[idx] > best) begin
                    cand_idx = idx;
                    cand_val = snap[idx];
                end
                if (idx == IDX_W'(NUM_DISP - 1)) begin
                    state_n     = IDLE;
                    best_disp_n = cand_idx;
                    best_val_n  = cand_val;
                    valid_n     = 1'b1;
                end else begin
                    idx_n      = idx + IDX_W'(1);
                    best_idx_n = cand_idx;
                    best_n     = cand_val;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            best_idx    <= '0;
            best        <= '0;
            best_disp_q <= '0;
            best_val_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NUM_DISP; k++) snap[k] <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            best_idx    <= best_idx_n;
            best        <= best_n;
            best_disp_q <= best_disp_n;
            best_val_q  <= best_val_n;
            valid_q     <= valid_n;
            overrun_q   <= overrun_n;
            if (snap_en) begin
                for (int k = 0; k < NUM_DISP; k++) snap[k] <= total[k];
            end
        end
    end

    always_comb begin
        corr_flat = '0;
        for (int k = 0; k < NUM_DISP; k++) corr_flat[k*ACC_W +: ACC_W] = snap[k];
    end

    assign bus.corr_out  = corr_flat;
    assign bus.best_disp = best_disp_q;
    assign bus.best_val  = best_val_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = overrun_q;

endmodule
